// File: rtl/led_bounce.sv
// led_bounce: a single lit LED sweeps back and forth across LED_COUNT outputs,
// pausing END_HOLD strobe intervals at each end; a flip request reverses the
// sweep at the next strobe.
//
// Ports:
//   i_clk    - clock, all logic on the rising edge
//   i_reset  - synchronous active-high reset
//   i_en     - 1 = run, 0 = freeze prescaler and sweep
//   i_flip   - direction-reversal request, sampled every cycle
//   o_led    - one-hot lit LED
//   o_dir    - 1 = next motion toward the MSB, 0 = toward bit 0
//   o_end    - one-cycle pulse when the lit LED arrives at either end
module led_bounce #(
    parameter int unsigned COUNTER_WIDTH = 25,
    parameter int unsigned LED_COUNT     = 4,
    parameter int unsigned END_HOLD      = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic                 i_flip,
    output logic [LED_COUNT-1:0] o_led,
    output logic                 o_dir,
    output logic                 o_end
);

    localparam int unsigned CNT_EXT_W = COUNTER_WIDTH + 1;
    localparam int unsigned HOLD_W    = 8;

    // Two-bit encoding with all four codes used, so no code is unreachable.
    typedef enum logic [1:0] {
        S_UP      = 2'd0,
        S_DOWN    = 2'd1,
        S_HOLD_HI = 2'd2,
        S_HOLD_LO = 2'd3
    } state_t;

    state_t                   state;
    logic [COUNTER_WIDTH-1:0] counter;
    logic                     stb;
    logic [HOLD_W-1:0]        hold_cnt;
    logic                     flip_pend;

    logic                     flip_eff_c;
    logic                     moving_c;
    logic                     go_up_c;
    logic                     advance_c;
    logic [LED_COUNT-1:0]     next_led_c;

    // Direction of the next shift and whether this strobe moves the LED.
    always_comb begin
        flip_eff_c = flip_pend | i_flip;
        moving_c   = (state == S_UP) || (state == S_DOWN);
        go_up_c    = 1'b1;
        case (state)
            S_UP:      go_up_c = ~flip_eff_c;
            S_DOWN:    go_up_c = flip_eff_c;
            S_HOLD_HI: go_up_c = 1'b0;
            default:   go_up_c = 1'b1;
        endcase
        advance_c  = moving_c || (hold_cnt == HOLD_W'(1));
        next_led_c = go_up_c ? (o_led << 1) : (o_led >> 1);
    end

    // Prescaler, sweep state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            counter   <= '0;
            stb       <= 1'b0;
            o_led     <= LED_COUNT'(1);
            state     <= S_HOLD_LO;
            hold_cnt  <= HOLD_W'(1);
            o_dir     <= 1'b1;
            o_end     <= 1'b0;
            flip_pend <= 1'b0;
        end else begin
            o_end <= 1'b0;

            if (i_en) begin
                {stb, counter} <= CNT_EXT_W'({1'b0, counter}) + CNT_EXT_W'(1);
            end else begin
                stb <= 1'b0;
            end

            // Flip requests are only remembered while the LED is moving.
            if (i_flip && moving_c) begin
                flip_pend <= 1'b1;
            end

            if (i_en && stb) begin
                if (advance_c) begin
                    o_led     <= next_led_c;
                    flip_pend <= 1'b0;
                    if (next_led_c[LED_COUNT-1]) begin
                        state    <= S_HOLD_HI;
                        hold_cnt <= HOLD_W'(END_HOLD);
                        o_dir    <= 1'b0;
                        o_end    <= 1'b1;
                    end else if (next_led_c[0]) begin
                        state    <= S_HOLD_LO;
                        hold_cnt <= HOLD_W'(END_HOLD);
                        o_dir    <= 1'b1;
                        o_end    <= 1'b1;
                    end else begin
                        state <= go_up_c ? S_UP : S_DOWN;
                        o_dir <= go_up_c;
                    end
                end else begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_bounce.sv
// Directed bench for led_bounce with COUNTER_WIDTH=2, LED_COUNT=4, END_HOLD=2.
// Edges are numbered from reset release; the strobe register is set on edge
// 4k and the LED updates on edge 4k+1.
module tb_led_bounce;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_en;
    logic       i_flip;
    logic [3:0] o_led;
    logic       o_dir;
    logic       o_end;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic [3:0] led_tbl [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000,
                                 4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0010};
    logic       dir_tbl [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       end_tbl [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    led_bounce #(
        .COUNTER_WIDTH(2),
        .LED_COUNT    (4),
        .END_HOLD     (2)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_en   (i_en),
        .i_flip (i_flip),
        .o_led  (o_led),
        .o_dir  (o_dir),
        .o_end  (o_end)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic reset_dut();
        i_reset = 1'b1;
        i_en    = 1'b1;
        i_flip  = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        edge_n  = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got led=%b dir=%b end=%b want 0001 1 0", o_led, o_dir, o_end);
        end
        // Reset held across several would-be strobes, with flip asserted.
        i_reset = 1'b1;
        i_flip  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({o_led, o_dir, o_end} !== {4'b0001, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got led=%b dir=%b end=%b want 0001 1 0", i, o_led, o_dir, o_end);
            end
        end
        i_reset = 1'b0;
        i_flip  = 1'b0;
    endtask

    task automatic test_free_run();
        int idx;
        logic step;
        reset_dut();
        idx = 0;
        for (int e = 1; e <= 37; e++) begin
            tick();
            step = (e >= 5) && (((e - 1) % 4) == 0);
            if (step) idx = (e - 1) / 4;
            checks++;
            if ({o_led, o_dir, o_end} !== {led_tbl[idx], dir_tbl[idx], step & end_tbl[idx]}) begin
                errors++;
                $display("FAIL free_run e=%0d got led=%b dir=%b end=%b want led=%b dir=%b end=%b",
                         e, o_led, o_dir, o_end, led_tbl[idx], dir_tbl[idx], step & end_tbl[idx]);
            end
        end
    endtask

    task automatic test_flip_moving();
        reset_dut();
        run_to(9);
        checks++;
        if ({o_led, o_dir} !== {4'b0100, 1'b1}) begin
            errors++;
            $display("FAIL flip_pre got led=%b dir=%b want 0100 1", o_led, o_dir);
        end
        i_flip = 1'b1;
        tick();
        i_flip = 1'b0;
        run_to(13);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0010, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flip_reverse got led=%b dir=%b end=%b want 0010 0 0", o_led, o_dir, o_end);
        end
        run_to(17);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0001, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL flip_arrive_lo got led=%b dir=%b end=%b want 0001 1 1", o_led, o_dir, o_end);
        end
    endtask

    task automatic test_flip_in_hold();
        reset_dut();
        run_to(13);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b1000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL hold_hi_arrive got led=%b dir=%b end=%b want 1000 0 1", o_led, o_dir, o_end);
        end
        i_flip = 1'b1;
        tick();
        tick();
        i_flip = 1'b0;
        run_to(17);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b1000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hold_hi_stay got led=%b dir=%b end=%b want 1000 0 0", o_led, o_dir, o_end);
        end
        run_to(21);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hold_hi_leave got led=%b dir=%b end=%b want 0100 0 0", o_led, o_dir, o_end);
        end
        run_to(25);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0010, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hold_hi_no_pend got led=%b dir=%b end=%b want 0010 0 0", o_led, o_dir, o_end);
        end
    endtask

    task automatic test_flip_on_stb();
        reset_dut();
        run_to(8);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0010, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stb_flip_pre got led=%b dir=%b end=%b want 0010 1 0", o_led, o_dir, o_end);
        end
        i_flip = 1'b1;
        tick();
        i_flip = 1'b0;
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0001, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL stb_flip_now got led=%b dir=%b end=%b want 0001 1 1", o_led, o_dir, o_end);
        end
        run_to(13);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stb_flip_hold got led=%b dir=%b end=%b want 0001 1 0", o_led, o_dir, o_end);
        end
        run_to(17);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0010, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stb_flip_leave got led=%b dir=%b end=%b want 0010 1 0", o_led, o_dir, o_end);
        end
    endtask

    task automatic test_back_to_back_flip();
        reset_dut();
        run_to(5);
        i_flip = 1'b1;
        tick();
        i_flip = 1'b0;
        tick();
        i_flip = 1'b1;
        tick();
        i_flip = 1'b0;
        run_to(9);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0001, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL multi_flip got led=%b dir=%b end=%b want 0001 1 1", o_led, o_dir, o_end);
        end
    endtask

    task automatic test_enable();
        reset_dut();
        run_to(6);
        i_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({o_led, o_dir, o_end} !== {4'b0010, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL en_freeze cyc=%0d got led=%b dir=%b end=%b want 0010 1 0", i, o_led, o_dir, o_end);
            end
        end
        i_en = 1'b1;
        tick();
        tick();
        checks++;
        if (o_led !== 4'b0010) begin
            errors++;
            $display("FAIL en_resume_early got led=%b want 0010", o_led);
        end
        tick();
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL en_resume_step got led=%b dir=%b end=%b want 0100 1 0", o_led, o_dir, o_end);
        end
        run_to(23);
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b1000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL en_resume_next got led=%b dir=%b end=%b want 1000 0 1", o_led, o_dir, o_end);
        end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        run_to(21);
        checks++;
        if ({o_led, o_dir} !== {4'b0100, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_pre got led=%b dir=%b want 0100 0", o_led, o_dir);
        end
        i_reset = 1'b1;
        i_flip  = 1'b1;
        tick();
        i_reset = 1'b0;
        i_flip  = 1'b0;
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_now got led=%b dir=%b end=%b want 0001 1 0", o_led, o_dir, o_end);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (o_led !== 4'b0001) begin
                errors++;
                $display("FAIL mid_reset_wait cyc=%0d got led=%b want 0001", i, o_led);
            end
        end
        tick();
        checks++;
        if ({o_led, o_dir, o_end} !== {4'b0010, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_first got led=%b dir=%b end=%b want 0010 1 0", o_led, o_dir, o_end);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_en    = 1'b1;
        i_flip  = 1'b0;
        test_reset();
        test_free_run();
        test_flip_moving();
        test_flip_in_hold();
        test_flip_on_stb();
        test_back_to_back_flip();
        test_enable();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_bounce.md
LED_BOUNCE -- requirements
Module: led_bounce

Interface
REQ-001 The block SHALL have parameter COUNTER_WIDTH, default 25, the prescaler width; one strobe per 2^COUNTER_WIDTH enabled cycles.
REQ-002 The block SHALL have parameter LED_COUNT, default 4, the number of LEDs; the legal range is 2 or more.
REQ-003 The block SHALL have parameter END_HOLD, default 2, the number of strobe intervals the end LED stays lit; the legal range is 1..255.
REQ-004 The block SHALL have port i_clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_reset, input, width 1, a synchronous active-high reset.
REQ-006 The block SHALL have port i_en, input, width 1: 1 = run, 0 = freeze prescaler and FSM.
REQ-007 The block SHALL have port i_flip, input, width 1, a direction-reversal request, sampled every cycle.
REQ-008 The block SHALL have port o_led, output, width LED_COUNT, the one-hot lit LED.
REQ-009 The block SHALL have port o_dir, output, width 1: 1 = next motion toward the MSB, 0 = toward bit 0.
REQ-010 The block SHALL have port o_end, output, width 1: a one-cycle pulse when the lit LED arrives at either end.

Function
REQ-011 Prescaler: while i_en=1, {stb, counter} <= counter + 1 each cycle; stb is the registered carry out, high for exactly 1 cycle per 2^COUNTER_WIDTH enabled cycles.
REQ-012 While i_en=0, counter SHALL hold and stb SHALL be 0; FSM, o_led, o_dir and hold_cnt SHALL hold.
REQ-013 The FSM SHALL have states S_UP, S_DOWN, S_HOLD_HI and S_HOLD_LO; all FSM and o_led updates SHALL occur only on cycles with stb=1.
REQ-014 In S_UP on stb, o_led SHALL shift one position toward the MSB; in S_DOWN on stb, one position toward bit 0; the shift is not a rotate and no bit wraps.
REQ-015 Any shift that lands on bit LED_COUNT-1 SHALL enter S_HOLD_HI, and one that lands on bit 0 SHALL enter S_HOLD_LO; both load hold_cnt=END_HOLD and assert o_end on the same edge as the o_led update.
REQ-016 In S_HOLD_x on stb: if hold_cnt==1, shift away from the end and enter S_DOWN (from HI) or S_UP (from LO), or the opposite hold if the shift lands on an end (LED_COUNT=2); else hold_cnt decrements.
REQ-017 The end LED SHALL therefore stay lit for exactly END_HOLD strobe intervals; interior LEDs stay lit for 1 strobe interval.
REQ-018 o_dir SHALL be 1 in S_UP and S_HOLD_LO, and 0 in S_DOWN and S_HOLD_HI.
REQ-019 i_flip=1 in a cycle while in S_UP or S_DOWN SHALL set a sticky flip_pend flag.
REQ-020 i_flip SHALL be ignored in hold states, and flip_pend SHALL be cleared on entry to any hold state.
REQ-021 On stb with flip_pend=1 in a moving state, the shift SHALL go the opposite way, the state SHALL swap S_UP/S_DOWN (or enter a hold per REQ-015), and flip_pend SHALL clear.
REQ-022 i_flip arriving in the same cycle as stb SHALL take effect at that stb.
REQ-023 Multiple i_flip pulses between two strobes SHALL count as one request.
REQ-024 o_end SHALL be 0 in every cycle not covered by REQ-015.
REQ-025 o_led SHALL always be one-hot; no illegal state is reachable.
REQ-026 Unreachable state encodings SHALL recover to the reset state.

Reset
REQ-027 While i_reset=1, on any clock edge: counter=0, stb=0, o_led=1 (bit 0), state=S_HOLD_LO, hold_cnt=1, o_dir=1, o_end=0, flip_pend=0.
REQ-028 Reset SHALL take priority over i_en, i_flip and stb; mid-sweep reset SHALL restore REQ-027 values on the next edge.
REQ-029 After reset release, the first stb SHALL move o_led to bit 1.

Verification
All scenarios use COUNTER_WIDTH=2, LED_COUNT=4, END_HOLD=2, i_en=1, so stb fires every 4th cycle.
REQ-030 Reset then free-run: o_led per strobe SHALL be 0001,0010,0100,1000,1000,0100,0010,0001,0001,0010; o_end SHALL pulse on arrival at 1000 and at 0001; o_dir SHALL be 1,1,1,0,0,0,0,1,1,1.
REQ-031 i_flip pulsed while o_led=0100 in S_UP: the next stb SHALL give 0010 with o_dir=0, then 0001 with o_end=1.
REQ-032 i_flip pulsed during S_HOLD_HI (o_led=1000): it SHALL be ignored, and the sequence continues 1000,0100 unchanged.
REQ-033 i_flip asserted in the same cycle as stb, at o_led=0010 in S_UP: o_led SHALL become 0001 and the state S_HOLD_LO.
REQ-034 i_en=0 for 10 cycles mid-interval: o_led and counter SHALL freeze, no stb occurs, and the strobe phase resumes exactly where it stopped.
REQ-035 i_reset pulsed for 1 cycle at o_led=0100 in S_DOWN: the next edge SHALL give o_led=0001, o_dir=1, o_end=0, and the first stb afterwards SHALL give 0010.
